// File: rtl/dmem_port_arbiter.sv
// Shares the data-RAM port between the core (absolute priority) and one external requester. Optional abort: DMEM_ARB_TIMEOUT_EN.
// Latency: core path is combinational; an ext access lands 1 cycle after ext_req if the core is idle, and ext_ack follows 1 cycle later.
// Backpressure: the core is never stalled; ext_req is held until ext_ack, and every core access while pending adds one cycle.
module dmem_port_arbiter #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_W_en,
    input  logic        core_R_en,
    input  logic [2:0]  core_RW_type,
    input  logic [31:0] core_ram_addr,
    input  logic [31:0] core_store_data,
    output logic [31:0] core_load_data,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [2:0]  ext_type,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        ext_err,
    output logic        ext_busy,
    output logic        W_en,
    output logic        R_en,
    output logic [2:0]  RW_type,
    output logic [31:0] ram_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        core_act;
    logic        ext_grant;
    logic        timeout_hit;
    logic        ext_we_q;
    logic [2:0]  ext_type_q;
    logic [31:0] ext_addr_q;
    logic [31:0] ext_wdata_q;

    // A timeout that the counter can never reach would silently disable the abort.
    if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
        $error("dmem_port_arbiter: TIMEOUT must be in 1..2^TO_W-1");
    end

    assign core_act       = core_W_en | core_R_en;
    assign ext_grant      = (state == PEND) && !core_act;
    assign ext_ack        = (state == DONE);
    assign ext_busy       = (state != IDLE);
    assign core_load_data = load_data;

`ifdef DMEM_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wait_cnt;
    logic            ext_err_q;

    // Abort only when the core takes yet another cycle after TIMEOUT-1 blocked ones.
    assign timeout_hit = (state == PEND) && core_act && (wait_cnt == TO_W'(TIMEOUT - 1));
    assign ext_err     = ext_err_q && (state == DONE);

    // Saturating count of core-blocked cycles; error flag lives for the DONE cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            ext_err_q <= 1'b0;
        end else begin
            if (state == IDLE && ext_req) begin
                wait_cnt <= '0;
            end else if (state == PEND && core_act && wait_cnt != {TO_W{1'b1}}) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (state == DONE) begin
                ext_err_q <= 1'b0;
            end else if (timeout_hit) begin
                ext_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ext_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM port mux: the core passes through unless the ext request is granted.
    always_comb begin
        state_nxt  = state;
        W_en       = core_W_en;
        R_en       = core_R_en;
        RW_type    = core_RW_type;
        ram_addr   = core_ram_addr;
        store_data = core_store_data;
        case (state)
            IDLE:    if (ext_req) state_nxt = PEND;
            PEND:    if (ext_grant || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (ext_grant) begin
            W_en       = ext_we_q;
            R_en       = !ext_we_q;
            RW_type    = ext_type_q;
            ram_addr   = ext_addr_q;
            store_data = ext_wdata_q;
        end
    end

    // Request latch on acceptance, and read-data capture in the granted cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_we_q    <= 1'b0;
            ext_type_q  <= 3'b000;
            ext_addr_q  <= 32'h0;
            ext_wdata_q <= 32'h0;
            ext_rdata   <= 32'h0;
        end else begin
            if (state == IDLE && ext_req) begin
                ext_we_q    <= ext_we;
                ext_type_q  <= ext_type;
                ext_addr_q  <= ext_addr;
                ext_wdata_q <= ext_wdata;
            end
            if (ext_grant && !ext_we_q) begin
                ext_rdata <= load_data;
            end
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter that shares the single data-RAM port (W_en / R_en / RW_type / ram_addr / store_data / load_data) between the single-cycle RISC-V core and one external requester (debug loader / DMA). The core cannot stall, so it has absolute priority. The external requester is served in cycles where the core makes no memory access, through a latched request / one-cycle acknowledge handshake. The block sits between the core's data port and the data RAM.

## Interface
Parameters:
- TO_W, 8, width of the wait counter
- TIMEOUT, 200, blocked cycles before a pending request is aborted (1..2^TO_W-1); used only with DMEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_W_en  in  1  core store request
- core_R_en  in  1  core load request
- core_RW_type  in  3  core access size/sign (func3 encoding)
- core_ram_addr  in  32  core byte address
- core_store_data  in  32  core store data
- core_load_data  out  32  load data returned to core
- ext_req  in  1  external request, level, held until ext_ack
- ext_we  in  1  1 = write, 0 = read
- ext_type  in  3  access size/sign, same encoding as RW_type
- ext_addr  in  32  external byte address
- ext_wdata  in  32  external write data
- ext_ack  out  1  one-cycle completion pulse
- ext_rdata  out  32  registered read data
- ext_err  out  1  abort flag, valid with ext_ack
- ext_busy  out  1  request latched and not yet acknowledged
- W_en, R_en  out  1 each  RAM write/read enable
- RW_type  out  3  RAM access type
- ram_addr  out  32  RAM address
- store_data  out  32  RAM write data
- load_data  in  32  RAM read data, combinational in the access cycle

## Operation
- State machine IDLE, PEND, DONE. Reset state is IDLE.
- Core priority: core_act = core_W_en | core_R_en.
- ext_grant = (state == PEND) & ~core_act, combinational.
- RAM mux when ext_grant = 1:
  - W_en = ext_we_q, R_en = ~ext_we_q
  - RW_type, ram_addr, store_data from the latched ext registers
- RAM mux otherwise: all RAM outputs pass the core_* inputs through unchanged.
- core_load_data = load_data always.
- IDLE: if ext_req = 1, latch ext_we, ext_type, ext_addr and ext_wdata, clear the wait counter, go to PEND. Ext inputs are ignored after the latch.
- PEND, ext_grant = 1:
  - read: capture load_data into ext_rdata at the clock edge
  - write: ext_rdata is left unchanged
  - go to DONE
- PEND, core_act = 1: stay in PEND and increment the wait counter.
- DONE: ext_ack = 1 for exactly one cycle, then go to IDLE. ext_req is not sampled in DONE.
- The requester drops ext_req in the ack cycle. If ext_req is still high in the following IDLE cycle, it is accepted as a new request.
- ext_busy = (state != IDLE).
- ext_rdata holds its value until the next completed external read.

## Timing
- Reset (async, rst_n = 0):
  - state = IDLE
  - ext_ack = 0, ext_err = 0, ext_busy = 0, ext_rdata = 0
  - latched registers = 0, wait counter = 0
  - RAM port passes the core signals through
- Reset asserted mid-transaction: the request is dropped, no ack is issued, and no RAM access is driven after the reset.
- Minimum latency with the core idle:
  - ext_req rises in cycle 0; state = PEND in cycle 1, and the RAM access happens in cycle 1
  - state = DONE in cycle 2: ext_ack = 1 and ext_rdata is valid
- Each cycle with core_act = 1 while in PEND adds one cycle of latency.
- The core never sees added latency or a modified access.
- Wait counter: TO_W bits, saturating.

## Configuration
- DMEM_ARB_TIMEOUT_EN defined:
  - in PEND, if core_act = 1 and the counter equals TIMEOUT-1, go to DONE with ext_err = 1 and no RAM access
  - ext_err is asserted only together with ext_ack
  - ext_err is cleared on the next IDLE entry
- DMEM_ARB_TIMEOUT_EN undefined:
  - a pending request waits indefinitely
  - ext_err is tied to 0
  - the counter logic is absent

## Test plan
- Core idle, ext read addr 0x10, RAM word 0xDEADBEEF, ext_req in cycle 0 -> R_en = 1 and ram_addr = 0x10 in cycle 1; ext_ack = 1 and ext_rdata = 0xDEADBEEF in cycle 2; ext_busy = 0 in cycle 3.
- Core load active in cycles 1-3, ext write 0x20 ← 0x12345678 requested in cycle 0 -> RAM port carries the core's access in cycles 1-3; W_en = 1 with the ext address and data in cycle 4; ext_ack in cycle 5; ext_rdata unchanged.
- Ext inputs changed to addr 0x40 in cycle 1 after the latch -> the access in cycle 1 still uses addr 0x10.
- ext_req held high through ack -> a second access starts; ext_ack pulses in cycles 2 and 5, never two consecutive cycles.
- rst_n pulled low in cycle 1 of a pending request -> all outputs go to reset values immediately; no ext_ack follows; the RAM port reverts to the core.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT = 4, core busy continuously, ext_req in cycle 0 -> ext_ack = 1 and ext_err = 1 in cycle 5; no ext access appears on the RAM port; without the macro, ext_busy stays 1 and ext_ack stays 0.
